id_stage: RTL and testbench

- Decode stage of the 5-stage LEGv8 pipeline. Consumer of the fetch-stage outputs instruction_D and current_pc_D.
- Decodes the instruction, reads the 32x64 register file, sign-extends immediates and detects load-use hazards.
- Drives PCWrite and IF_ID_Write back to the fetch stage and registers all results into the ID/EX pipeline register.
- The write-back port from the WB stage terminates here.

---
 rtl/legv8_pkg.sv | 59 +++++
 rtl/register_file.sv | 44 ++++
 rtl/id_stage.sv | 198 +++++++++++++++++++
 tb/tb_id_stage.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// Shared LEGv8 decode definitions: opcode fields, ALU control codes and the
// control bundle carried through the ID/EX pipeline register.
package legv8_pkg;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI = 10'b1101000100;

    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [5:0]  OP_B    = 6'b000101;

    typedef enum logic [3:0] {
        ALU_AND   = 4'b0000,
        ALU_ORR   = 4'b0001,
        ALU_ADD   = 4'b0010,
        ALU_SUB   = 4'b0110,
        ALU_PASSB = 4'b0111
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_R,
        CLS_I,
        CLS_LDUR,
        CLS_STUR,
        CLS_CBZ,
        CLS_B
    } instr_class_e;

    typedef struct packed {
        logic      reg_write;
        logic      mem_read;
        logic      mem_write;
        logic      mem_to_reg;
        logic      alu_src;
        logic      branch;
        logic      uncond_branch;
        alu_ctrl_e alu_ctrl;
    } ctrl_t;

    // A bubble is indistinguishable from a decoded NOP.
    localparam ctrl_t CTRL_BUBBLE = '{
        reg_write:     1'b0,
        mem_read:      1'b0,
        mem_write:     1'b0,
        mem_to_reg:    1'b0,
        alu_src:       1'b0,
        branch:        1'b0,
        uncond_branch: 1'b0,
        alu_ctrl:      ALU_ADD
    };

endpackage

// File: rtl/register_file.sv
// 32-entry register file: two combinational read ports, one write port,
// X31 hard-wired to zero and same-cycle write-back bypass.
module register_file
    import legv8_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        i_rd_addr1,
    input  logic [4:0]        i_rd_addr2,
    output logic [DATA_W-1:0] o_rd_data1,
    output logic [DATA_W-1:0] o_rd_data2,
    input  logic              i_wr_en,
    input  logic [4:0]        i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data
);

    logic [DATA_W-1:0] r_regs [0:31];
    logic              w_wr_ok;

    assign w_wr_ok = i_wr_en && (i_wr_addr != 5'd31);

    // NOTE: this array is reset entry by entry, so it maps to flops rather than
    // a RAM macro; that is the price of a cleared register file after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

    // Write-back lands in the same cycle it is read, so WB never needs a stall.
    assign o_rd_data1 = (i_rd_addr1 == 5'd31)                   ? '0        :
                        (w_wr_ok && (i_wr_addr == i_rd_addr1)) ? i_wr_data :
                                                                 r_regs[i_rd_addr1];
    assign o_rd_data2 = (i_rd_addr2 == 5'd31)                   ? '0        :
                        (w_wr_ok && (i_wr_addr == i_rd_addr2)) ? i_wr_data :
                                                                 r_regs[i_rd_addr2];

endmodule

// File: rtl/id_stage.sv
// LEGv8 decode stage: instruction decode, register read, immediate extension,
// load-use hazard detection and the ID/EX pipeline register.
module id_stage
    import legv8_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int PC_W   = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instruction_D,
    input  logic [PC_W-1:0]   current_pc_D,
    input  logic              flush_E,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              PCWrite,
    output logic              IF_ID_Write,
    output logic [PC_W-1:0]   pc_E,
    output logic [DATA_W-1:0] read_data1_E,
    output logic [DATA_W-1:0] read_data2_E,
    output logic [DATA_W-1:0] imm_E,
    output logic [4:0]        rn_E,
    output logic [4:0]        rm_E,
    output logic [4:0]        rd_E,
    output logic              reg_write_E,
    output logic              mem_read_E,
    output logic              mem_write_E,
    output logic              mem_to_reg_E,
    output logic              alu_src_E,
    output logic              branch_E,
    output logic              uncond_branch_E,
    output logic [3:0]        alu_ctrl_E
);

    instr_class_e      w_class;
    ctrl_t             w_ctrl;
    logic [DATA_W-1:0] w_imm;
    logic [4:0]        w_rn;
    logic [4:0]        w_rm;
    logic [4:0]        w_rd;
    logic              w_uses_rn;
    logic              w_uses_rm;
    logic              w_stall;
    logic [DATA_W-1:0] w_rd_data1;
    logic [DATA_W-1:0] w_rd_data2;

    logic [PC_W-1:0]   r_pc;
    logic [DATA_W-1:0] r_rd_data1;
    logic [DATA_W-1:0] r_rd_data2;
    logic [DATA_W-1:0] r_imm;
    logic [4:0]        r_rn;
    logic [4:0]        r_rm;
    logic [4:0]        r_rd;
    ctrl_t             r_ctrl;

    // NOTE: every signal assigned in an always_comb gets a default on entry, so
    // no path through the if/case chain can leave it unassigned and infer a latch.
    always_comb begin
        w_class = CLS_NOP;
        if ((instruction_D[31:21] == OP_ADD) || (instruction_D[31:21] == OP_SUB) ||
            (instruction_D[31:21] == OP_AND) || (instruction_D[31:21] == OP_ORR)) begin
            w_class = CLS_R;
        end else if (instruction_D[31:21] == OP_LDUR) begin
            w_class = CLS_LDUR;
        end else if (instruction_D[31:21] == OP_STUR) begin
            w_class = CLS_STUR;
        end else if ((instruction_D[31:22] == OP_ADDI) || (instruction_D[31:22] == OP_SUBI)) begin
            w_class = CLS_I;
        end else if (instruction_D[31:24] == OP_CBZ) begin
            w_class = CLS_CBZ;
        end else if (instruction_D[31:26] == OP_B) begin
            w_class = CLS_B;
        end
    end

    always_comb begin
        w_ctrl    = CTRL_BUBBLE;
        w_imm     = '0;
        w_uses_rn = 1'b0;
        w_uses_rm = 1'b0;
        case (w_class)
            CLS_R: begin
                w_ctrl.reg_write = 1'b1;
                w_uses_rn        = 1'b1;
                w_uses_rm        = 1'b1;
                case (instruction_D[31:21])
                    OP_SUB:  w_ctrl.alu_ctrl = ALU_SUB;
                    OP_AND:  w_ctrl.alu_ctrl = ALU_AND;
                    OP_ORR:  w_ctrl.alu_ctrl = ALU_ORR;
                    default: w_ctrl.alu_ctrl = ALU_ADD;
                endcase
            end
            CLS_I: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.alu_ctrl  = (instruction_D[31:22] == OP_SUBI) ? ALU_SUB : ALU_ADD;
                w_uses_rn        = 1'b1;
                w_imm            = {{(DATA_W-12){1'b0}}, instruction_D[21:10]};
            end
            CLS_LDUR: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_read   = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.alu_src    = 1'b1;
                w_uses_rn         = 1'b1;
                w_imm             = {{(DATA_W-9){instruction_D[20]}}, instruction_D[20:12]};
            end
            CLS_STUR: begin
                w_ctrl.mem_write = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_uses_rn        = 1'b1;
                w_uses_rm        = 1'b1;
                w_imm            = {{(DATA_W-9){instruction_D[20]}}, instruction_D[20:12]};
            end
            CLS_CBZ: begin
                w_ctrl.branch   = 1'b1;
                w_ctrl.alu_ctrl = ALU_PASSB;
                w_uses_rm       = 1'b1;
                w_imm           = {{(DATA_W-19){instruction_D[23]}}, instruction_D[23:5]};
            end
            CLS_B: begin
                w_ctrl.uncond_branch = 1'b1;
                w_imm                = {{(DATA_W-26){instruction_D[25]}}, instruction_D[25:0]};
            end
            default: ;
        endcase
    end

    // Reg2Loc: stores and CBZ read their second operand from the Rt field.
    assign w_rn = instruction_D[9:5];
    assign w_rd = instruction_D[4:0];
    assign w_rm = ((w_class == CLS_STUR) || (w_class == CLS_CBZ)) ? instruction_D[4:0]
                                                                   : instruction_D[20:16];

    assign w_stall = r_ctrl.mem_read && (r_rd != 5'd31) &&
                     (((r_rd == w_rn) && w_uses_rn) || ((r_rd == w_rm) && w_uses_rm)) &&
                     !flush_E;

    assign PCWrite     = !w_stall;
    assign IF_ID_Write = !w_stall;

    register_file #(
        .DATA_W (DATA_W)
    ) u_register_file (
        .clk        (clk),
        .reset      (reset),
        .i_rd_addr1 (w_rn),
        .i_rd_addr2 (w_rm),
        .o_rd_data1 (w_rd_data1),
        .o_rd_data2 (w_rd_data2),
        .i_wr_en    (wb_reg_write),
        .i_wr_addr  (wb_rd),
        .i_wr_data  (wb_data)
    );

    // NOTE: pipeline state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc       <= '0;
            r_rd_data1 <= '0;
            r_rd_data2 <= '0;
            r_imm      <= '0;
            r_rn       <= '0;
            r_rm       <= '0;
            r_rd       <= '0;
            r_ctrl     <= '0;
        end else begin
            r_pc       <= current_pc_D;
            r_rd_data1 <= w_rd_data1;
            r_rd_data2 <= w_rd_data2;
            r_imm      <= w_imm;
            r_rn       <= w_rn;
            r_rm       <= w_rm;
            r_rd       <= w_rd;
            // Data fields load regardless; only the control bundle is squashed.
            r_ctrl     <= (flush_E || w_stall) ? CTRL_BUBBLE : w_ctrl;
        end
    end

    assign pc_E            = r_pc;
    assign read_data1_E    = r_rd_data1;
    assign read_data2_E    = r_rd_data2;
    assign imm_E           = r_imm;
    assign rn_E            = r_rn;
    assign rm_E            = r_rm;
    assign rd_E            = r_rd;
    assign reg_write_E     = r_ctrl.reg_write;
    assign mem_read_E      = r_ctrl.mem_read;
    assign mem_write_E     = r_ctrl.mem_write;
    assign mem_to_reg_E    = r_ctrl.mem_to_reg;
    assign alu_src_E       = r_ctrl.alu_src;
    assign branch_E        = r_ctrl.branch;
    assign uncond_branch_E = r_ctrl.uncond_branch;
    assign alu_ctrl_E      = r_ctrl.alu_ctrl;

endmodule

// File: tb/tb_id_stage.sv
// Directed, table-driven bench for id_stage: one record per cycle plus
// hand-written sequences for reset behaviour.
module tb_id_stage;

    localparam int DATA_W = 64;
    localparam int PC_W   = 10;

    // Expected control: {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, uncond}
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_R    = 7'b1000000;
    localparam logic [6:0] C_I    = 7'b1000100;
    localparam logic [6:0] C_LD   = 7'b1101100;
    localparam logic [6:0] C_ST   = 7'b0010100;
    localparam logic [6:0] C_CBZ  = 7'b0000010;
    localparam logic [6:0] C_B    = 7'b0000001;

    logic              clk = 1'b0;
    logic              reset;
    logic [31:0]       instruction_D;
    logic [PC_W-1:0]   current_pc_D;
    logic              flush_E;
    logic              wb_reg_write;
    logic [4:0]        wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              PCWrite;
    logic              IF_ID_Write;
    logic [PC_W-1:0]   pc_E;
    logic [DATA_W-1:0] read_data1_E;
    logic [DATA_W-1:0] read_data2_E;
    logic [DATA_W-1:0] imm_E;
    logic [4:0]        rn_E;
    logic [4:0]        rm_E;
    logic [4:0]        rd_E;
    logic              reg_write_E;
    logic              mem_read_E;
    logic              mem_write_E;
    logic              mem_to_reg_E;
    logic              alu_src_E;
    logic              branch_E;
    logic              uncond_branch_E;
    logic [3:0]        alu_ctrl_E;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    id_stage #(
        .DATA_W (DATA_W),
        .PC_W   (PC_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .instruction_D   (instruction_D),
        .current_pc_D    (current_pc_D),
        .flush_E         (flush_E),
        .wb_reg_write    (wb_reg_write),
        .wb_rd           (wb_rd),
        .wb_data         (wb_data),
        .PCWrite         (PCWrite),
        .IF_ID_Write     (IF_ID_Write),
        .pc_E            (pc_E),
        .read_data1_E    (read_data1_E),
        .read_data2_E    (read_data2_E),
        .imm_E           (imm_E),
        .rn_E            (rn_E),
        .rm_E            (rm_E),
        .rd_E            (rd_E),
        .reg_write_E     (reg_write_E),
        .mem_read_E      (mem_read_E),
        .mem_write_E     (mem_write_E),
        .mem_to_reg_E    (mem_to_reg_E),
        .alu_src_E       (alu_src_E),
        .branch_E        (branch_E),
        .uncond_branch_E (uncond_branch_E),
        .alu_ctrl_E      (alu_ctrl_E)
    );

    typedef struct {
        logic [31:0] instr;
        logic        flush;
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [63:0] wb_data;
        logic        pcw;
        logic [6:0]  ctrl;
        logic        chk_alu;
        logic [3:0]  alu;
        logic        chk_regs;
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic [4:0]  rd;
        logic        chk_imm;
        logic [63:0] imm;
        logic        chk_data;
        logic [63:0] rd1;
        logic [63:0] rd2;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] enc_r(input logic [10:0] op, input logic [4:0] rm,
                                          input logic [4:0] rn, input logic [4:0] rd);
        return {op, rm, 6'd0, rn, rd};
    endfunction

    function automatic logic [31:0] enc_d(input logic [10:0] op, input logic [8:0] imm9,
                                          input logic [4:0] rn, input logic [4:0] rt);
        return {op, imm9, 2'b00, rn, rt};
    endfunction

    function automatic logic [31:0] enc_i(input logic [9:0] op, input logic [11:0] imm12,
                                          input logic [4:0] rn, input logic [4:0] rd);
        return {op, imm12, rn, rd};
    endfunction

    function automatic vec_t mk(
        input logic [31:0] instr, input logic flush,
        input logic wb_we, input logic [4:0] wbr, input logic [63:0] wbd,
        input logic pcw, input logic [6:0] ctrl, input logic chk_alu, input logic [3:0] alu,
        input logic chk_regs, input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd,
        input logic chk_imm, input logic [63:0] imm,
        input logic chk_data, input logic [63:0] rd1, input logic [63:0] rd2);
        vec_t v;
        v.instr = instr;   v.flush = flush;
        v.wb_we = wb_we;   v.wb_rd = wbr;       v.wb_data = wbd;
        v.pcw = pcw;       v.ctrl = ctrl;       v.chk_alu = chk_alu;  v.alu = alu;
        v.chk_regs = chk_regs; v.rn = rn;       v.rm = rm;            v.rd = rd;
        v.chk_imm = chk_imm;   v.imm = imm;
        v.chk_data = chk_data; v.rd1 = rd1;     v.rd2 = rd2;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] act_ctrl();
        return {reg_write_E, mem_read_E, mem_write_E, mem_to_reg_E,
                alu_src_E, branch_E, uncond_branch_E};
    endfunction

    task automatic drive(input logic [31:0] instr, input logic flush, input logic we,
                         input logic [4:0] wbr, input logic [63:0] wbd, input logic [PC_W-1:0] pc);
        instruction_D = instr;
        flush_E       = flush;
        wb_reg_write  = we;
        wb_rd         = wbr;
        wb_data       = wbd;
        current_pc_D  = pc;
    endtask

    initial begin
        logic [31:0] i_add3, i_ld9, i_sub10;
        vec_t t;

        i_add3  = 32'h8B02_0023;
        i_ld9   = enc_d(11'b11111000010, 9'd8, 5'd1, 5'd9);
        i_sub10 = enc_r(11'b11001011000, 5'd2, 5'd9, 5'd10);

        // instr, flush, wb_we, wb_rd, wb_data, pcw, ctrl, chk_alu, alu,
        // chk_regs, rn, rm, rd, chk_imm, imm, chk_data, rd1, rd2
        vecs.push_back(mk(32'h0, 0, 1, 5'd1, 64'h5, 1, C_NONE, 1, 4'b0010, 1, 0, 0, 0, 1, 64'h0, 1, 64'h0, 64'h0));
        vecs.push_back(mk(i_add3, 0, 1, 5'd2, 64'h3, 1, C_R, 1, 4'b0010, 1, 1, 2, 3, 0, 64'h0, 1, 64'h5, 64'h3));
        vecs.push_back(mk(i_ld9, 0, 0, 5'd0, 64'h0, 1, C_LD, 1, 4'b0010, 1, 1, 0, 9, 1, 64'h8, 1, 64'h5, 64'h0));
        vecs.push_back(mk(i_sub10, 0, 0, 5'd0, 64'h0, 0, C_NONE, 1, 4'b0010, 0, 0, 0, 0, 0, 64'h0, 0, 64'h0, 64'h0));
        vecs.push_back(mk(i_sub10, 0, 0, 5'd0, 64'h0, 1, C_R, 1, 4'b0110, 1, 9, 2, 10, 0, 64'h0, 1, 64'h0, 64'h3));
        vecs.push_back(mk(32'h0, 0, 1, 5'd31, 64'hFF, 1, C_NONE, 1, 4'b0010, 0, 0, 0, 0, 0, 64'h0, 0, 64'h0, 64'h0));
        vecs.push_back(mk(enc_r(11'b10001011000, 5'd31, 5'd31, 5'd4), 0, 1, 5'd31, 64'hFF,
                          1, C_R, 1, 4'b0010, 1, 31, 31, 4, 0, 64'h0, 1, 64'h0, 64'h0));
        vecs.push_back(mk(enc_d(11'b11111000010, 9'd0, 5'd1, 5'd31), 0, 0, 5'd0, 64'h0,
                          1, C_LD, 1, 4'b0010, 1, 1, 0, 31, 1, 64'h0, 1, 64'h5, 64'h0));
        vecs.push_back(mk(enc_r(11'b10001011000, 5'd31, 5'd31, 5'd5), 0, 0, 5'd0, 64'h0,
                          1, C_R, 1, 4'b0010, 1, 31, 31, 5, 0, 64'h0, 1, 64'h0, 64'h0));
        vecs.push_back(mk(enc_d(11'b11111000010, 9'd0, 5'd2, 5'd7), 0, 1, 5'd7, 64'h1234,
                          1, C_LD, 1, 4'b0010, 1, 2, 0, 7, 1, 64'h0, 1, 64'h3, 64'h0));
        vecs.push_back(mk(enc_d(11'b11111000000, 9'h100, 5'd3, 5'd7), 0, 0, 5'd0, 64'h0,
                          0, C_NONE, 1, 4'b0010, 0, 0, 0, 0, 0, 64'h0, 0, 64'h0, 64'h0));
        vecs.push_back(mk(enc_d(11'b11111000000, 9'h100, 5'd3, 5'd7), 0, 0, 5'd0, 64'h0,
                          1, C_ST, 1, 4'b0010, 1, 3, 7, 7, 1, 64'hFFFF_FFFF_FFFF_FF00, 1, 64'h0, 64'h1234));
        vecs.push_back(mk({8'b10110100, 19'h7FFFF, 5'd5}, 0, 0, 5'd0, 64'h0,
                          1, C_CBZ, 1, 4'b0111, 1, 31, 5, 5, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h0, 64'h0));
        vecs.push_back(mk({6'b000101, 26'h2000000}, 0, 0, 5'd0, 64'h0,
                          1, C_B, 0, 4'b0000, 0, 0, 0, 0, 1, 64'hFFFF_FFFF_FE00_0000, 0, 64'h0, 64'h0));
        vecs.push_back(mk(enc_i(10'b1001000100, 12'hABC, 5'd1, 5'd6), 0, 0, 5'd0, 64'h0,
                          1, C_I, 0, 4'b0000, 1, 1, 10, 6, 1, 64'hABC, 1, 64'h5, 64'h0));
        vecs.push_back(mk(i_ld9, 0, 0, 5'd0, 64'h0, 1, C_LD, 1, 4'b0010, 1, 1, 0, 9, 1, 64'h8, 1, 64'h5, 64'h0));
        vecs.push_back(mk(i_sub10, 1, 0, 5'd0, 64'h0, 1, C_NONE, 1, 4'b0010, 0, 0, 0, 0, 0, 64'h0, 0, 64'h0, 64'h0));
        vecs.push_back(mk(32'h0, 0, 0, 5'd0, 64'h0, 1, C_NONE, 1, 4'b0010, 0, 0, 0, 0, 0, 64'h0, 0, 64'h0, 64'h0));

        // Reset state.
        reset = 1'b1;
        drive(32'h0, 1'b0, 1'b0, 5'd0, 64'h0, '0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_pcwrite", PCWrite, 1);
        check("rst_ifid", IF_ID_Write, 1);
        check("rst_ctrl", act_ctrl(), 0);
        check("rst_alu", alu_ctrl_E, 0);
        check("rst_rd1", read_data1_E, 0);
        check("rst_rd2", read_data2_E, 0);
        check("rst_pc", pc_E, 0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            logic [PC_W-1:0] pc;
            t  = vecs[i];
            pc = PC_W'(16 + 4 * i);
            drive(t.instr, t.flush, t.wb_we, t.wb_rd, t.wb_data, pc);
            #1;
            check($sformatf("v%0d_pcwrite", i), PCWrite, t.pcw);
            check($sformatf("v%0d_ifid", i), IF_ID_Write, t.pcw);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_ctrl", i), act_ctrl(), t.ctrl);
            if (t.chk_alu)  check($sformatf("v%0d_alu", i), alu_ctrl_E, t.alu);
            if (t.chk_regs) begin
                check($sformatf("v%0d_rn", i), rn_E, t.rn);
                check($sformatf("v%0d_rm", i), rm_E, t.rm);
                check($sformatf("v%0d_rd", i), rd_E, t.rd);
                check($sformatf("v%0d_pc", i), pc_E, pc);
            end
            if (t.chk_imm)  check($sformatf("v%0d_imm", i), imm_E, t.imm);
            if (t.chk_data) begin
                check($sformatf("v%0d_rd1", i), read_data1_E, t.rd1);
                check($sformatf("v%0d_rd2", i), read_data2_E, t.rd2);
            end
        end

        // Reset asserted in the middle of a load-use stall.
        drive(i_ld9, 1'b0, 1'b0, 5'd0, 64'h0, 10'h100);
        @(posedge clk);
        #1;
        drive(i_sub10, 1'b0, 1'b0, 5'd0, 64'h0, 10'h104);
        #1;
        check("mid_pre_stall", PCWrite, 0);
        reset = 1'b1;
        #1;
        check("mid_pcwrite", PCWrite, 1);
        check("mid_ifid", IF_ID_Write, 1);
        check("mid_mem_read", mem_read_E, 0);
        check("mid_reg_write", reg_write_E, 0);
        #2;
        reset = 1'b0;
        drive(i_add3, 1'b0, 1'b0, 5'd0, 64'h0, 10'h108);
        @(posedge clk);
        #1;
        check("post_rst_rd1", read_data1_E, 0);
        check("post_rst_rd2", read_data2_E, 0);
        check("post_rst_ctrl", act_ctrl(), C_R);
        check("post_rst_rd", rd_E, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
